// File: rtl/reaction_controller.sv
// Reaction-timer trial sequencer: press arms, random delay, LED on, ms count to next press.
// Optional best-time tracking when REACTION_BEST_TRACK_EN is defined; otherwise best_ms is constant.
module reaction_controller #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  output logic        led,
  output logic        busy,
  output logic        result_valid,
  output logic [13:0] reaction_ms,
  output logic        false_start,
  output logic        timeout,
  output logic [13:0] best_ms
);

  localparam int PW = $clog2(TICKS_PER_MS);
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS) + 1);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            button_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   delay_q, delay_d, delay_load;
  logic [13:0]     ms_q, ms_d;
  logic [13:0]     react_q, react_d;
  logic            fs_q, fs_d;
  logic            to_q, to_d;
  logic            led_q, busy_q, rv_q;
  logic            press, tick;

  assign press      = button & ~button_q;
  assign tick       = (presc_q == PW'(TICKS_PER_MS - 1));
  assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    if (lfsr_d == 16'h0000) lfsr_d = SEED;
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    ms_d    = ms_q;
    react_d = react_q;
    fs_d    = fs_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_WAIT;
          delay_d = delay_load;
        end
      end
      S_WAIT: begin
        // A press on the final delay tick still counts as a false start.
        if (press) begin
          state_d = S_DONE;
          fs_d    = 1'b1;
          react_d = 14'd0;
        end else if (tick) begin
          if (delay_q == DW'(1)) begin
            state_d = S_LIT;
            ms_d    = 14'd0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      S_LIT: begin
        if (press) begin
          state_d = S_DONE;
          react_d = ms_q;
        end else if (tick) begin
          ms_d = ms_q + 14'd1;
          if (ms_q == 14'(MAX_MS - 1)) begin
            state_d = S_DONE;
            to_d    = 1'b1;
            react_d = 14'(MAX_MS);
          end
        end
      end
      S_DONE: begin
        if (press) begin
          state_d = S_WAIT;
          delay_d = delay_load;
          react_d = 14'd0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        react_d = 14'd0;
        fs_d    = 1'b0;
        to_d    = 1'b0;
      end
    endcase
  end

  // Prescaler restarts on every state change so each state sees full ms periods.
  always_comb begin
    if ((state_d != state_q) || tick) presc_d = '0;
    else                              presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      button_q <= 1'b1;
      lfsr_q   <= SEED;
      presc_q  <= '0;
      delay_q  <= '0;
      ms_q     <= 14'd0;
      react_q  <= 14'd0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      button_q <= button;
      lfsr_q   <= lfsr_d;
      presc_q  <= presc_d;
      delay_q  <= delay_d;
      ms_q     <= ms_d;
      react_q  <= react_d;
      fs_q     <= fs_d;
      to_q     <= to_d;
      led_q    <= (state_d == S_LIT);
      busy_q   <= (state_d == S_WAIT) || (state_d == S_LIT);
      rv_q     <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign led          = led_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign reaction_ms  = react_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

`ifdef REACTION_BEST_TRACK_EN
  logic [13:0] best_q, best_d;

  // Only a genuine reaction (LIT left by a press) can improve the best time.
  always_comb begin
    best_d = best_q;
    if ((state_q == S_LIT) && (state_d == S_DONE) && !to_d && (react_d < best_q))
      best_d = react_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) best_q <= 14'h3FFF;
    else       best_q <= best_d;
  end

  assign best_ms = best_q;
`else
  assign best_ms = 14'h3FFF;
`endif

endmodule

// File: tb/tb_reaction_controller.sv
// Bench for reaction_controller: directed and random trials checked against a trial-level model
// (delay from LFSR sample, reported ms from press offset, best time as running minimum).
module tb_reaction_controller;

  localparam int T    = 4;
  localparam int MIND = 2;
  localparam int DB   = 2;
  localparam int MAXM = 5;

  logic        clk;
  logic        reset;
  logic        button;
  logic        led;
  logic        busy;
  logic        result_valid;
  logic [13:0] reaction_ms;
  logic        false_start;
  logic        timeout;
  logic [13:0] best_ms;

  int          checks;
  int          errors;
  logic [15:0] model_lfsr;
  logic [13:0] best_exp;

  reaction_controller #(
    .TICKS_PER_MS(T),
    .MIN_DELAY_MS(MIND),
    .DELAY_BITS  (DB),
    .MAX_MS      (MAXM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .led         (led),
    .busy        (busy),
    .result_valid(result_valid),
    .reaction_ms (reaction_ms),
    .false_start (false_start),
    .timeout     (timeout),
    .best_ms     (best_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pseudo-random source: x^16+x^14+x^13+x^11+1, one step per clock.
  initial model_lfsr = 16'hACE1;
  always @(posedge clk or posedge reset) begin
    if (reset) model_lfsr = 16'hACE1;
    else       model_lfsr = (model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] best_view();
`ifdef REACTION_BEST_TRACK_EN
    return best_exp;
`else
    return 14'h3FFF;
`endif
  endfunction

  // kind 0: press m cycles after LED on; kind 1: press m cycles into the wait; kind 2: never press.
  task automatic run_trial(input int kind, input int m);
    int   d, n, exp_ms;
    logic saw_led;
    d = MIND + int'(model_lfsr[DB-1:0]);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    check("busy_after_press", busy, 1);
    check("rv_after_press", result_valid, 0);
    check("fields_clear", {reaction_ms, false_start, timeout}, 0);
    if (kind == 1) begin
      m = 1 + (m - 1) % (d * T);
      saw_led = 1'b0;
      for (int i = 1; i < m; i++) begin
        @(negedge clk);
        saw_led |= led;
      end
      button = 1'b1;
      @(negedge clk);
      button = 1'b0;
      saw_led |= led;
      check("fs_led_never", saw_led, 0);
      check("fs_rv", result_valid, 1);
      check("fs_flag", false_start, 1);
      check("fs_ms", reaction_ms, 0);
      check("fs_busy", busy, 0);
      @(negedge clk);
      check("fs_rv_pulse", result_valid, 0);
      check("fs_hold", false_start, 1);
    end else begin
      n = 0;
      while (!led && n < d * T + 8) begin
        @(negedge clk);
        n++;
      end
      check("led_delay", n, d * T);
      if (kind == 0) begin
        repeat (m - 1) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        exp_ms = (m - 1) / T;
        if (exp_ms < int'(best_exp)) best_exp = 14'(exp_ms);
        check("react_rv", result_valid, 1);
        check("react_ms", reaction_ms, exp_ms);
        check("react_flags", {false_start, timeout, led, busy}, 0);
        check("react_best", best_ms, best_view());
        @(negedge clk);
        check("react_rv_pulse", result_valid, 0);
        check("react_hold", reaction_ms, exp_ms);
      end else begin
        n = 0;
        while (!result_valid && n < MAXM * T + 8) begin
          @(negedge clk);
          n++;
        end
        check("to_cycles", n, MAXM * T);
        check("to_flag", timeout, 1);
        check("to_ms", reaction_ms, MAXM);
        check("to_led", led, 0);
        @(negedge clk);
        check("to_hold", {timeout, result_valid}, 2'b10);
      end
    end
    check("best_after_trial", best_ms, best_view());
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    best_exp = 14'h3FFF;
    reset    = 1'b1;
    button   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {led, busy, result_valid, false_start, timeout}, 0);
    check("rst_ms", reaction_ms, 0);
    check("rst_best", best_ms, 14'h3FFF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_button_idle", busy, 0);
    button = 1'b0;
    @(negedge clk);

    run_trial(0, 13);
    run_trial(0, 6);
    run_trial(1, int'($urandom_range(1, 24)));
    run_trial(2, 0);
    run_trial(0, MAXM * T);
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       run_trial(0, int'($urandom_range(1, MAXM * T)));
        1:       run_trial(1, int'($urandom_range(1, 24)));
        default: run_trial(2, 0);
      endcase
    end

    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    n = 0;
    while (!led && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lit_before_reset", led, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_led_busy", {led, busy, result_valid}, 0);
    check("async_ms", reaction_ms, 0);
    check("async_best", best_ms, 14'h3FFF);
    @(negedge clk);
    reset    = 1'b0;
    best_exp = 14'h3FFF;
    @(negedge clk);
    check("post_reset_idle", {led, busy}, 0);
    run_trial(0, int'($urandom_range(1, MAXM * T)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
